// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler: arbitration
// state encoding and default geometry.
package rf_sched_pkg;

    typedef enum logic {
        ALU_PRI = 1'b0,
        LU_PRI  = 1'b1
    } sched_state_t;

    localparam int DEF_AW         = 5;
    localparam int DEF_XLEN       = 32;
    localparam int DEF_STARVE_LIM = 3;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: one reservation bit per architectural register,
// set on long-latency issue, cleared on long-unit writeback, x0 never busy.
module rf_scoreboard
    import rf_sched_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] chk_rd,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          chk_busy,
    output logic          any_busy
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;

    assign busy_next[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_bit
            // A set on the same edge as a clear wins: the new reservation survives.
            assign busy_next[gi] = (set_en && (set_rd == AW'(gi))) ||
                                   (busy_reg[gi] && !(clr_en && (clr_rd == AW'(gi))));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign rs1_busy = (rs1 != '0) && busy_reg[rs1];
    assign rs2_busy = (rs2 != '0) && busy_reg[rs2];
    assign chk_busy = (chk_rd != '0) && busy_reg[chk_rd];
    assign any_busy = |busy_reg;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: RAW/WAW hazard tracking for long-latency results and
// a starvation-limited arbiter between the ALU and the long unit.
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int XLEN       = DEF_XLEN,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic            iss_long,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            stall,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_wd,
    output logic            alu_ready,
    input  logic            lu_valid,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_wd,
    output logic            lu_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_adr3,
    output logic [XLEN-1:0] rf_wd3,
    output logic            idle
);

    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    sched_state_t  state_reg;
    logic [CW-1:0] cnt_reg;

    logic rs1_busy;
    logic rs2_busy;
    logic rd_busy;
    logic any_busy;
    logic set_en;

    assign iss_ready = !rst && !(iss_long && rd_busy);
    assign set_en    = iss_valid && iss_ready && iss_long && (iss_rd != '0);
    assign stall     = rs1_busy || rs2_busy;
    assign idle      = !any_busy && (state_reg == ALU_PRI);

    rf_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_rd   (iss_rd),
        .clr_en   (lu_ready),
        .clr_rd   (lu_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .chk_rd   (iss_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .chk_busy (rd_busy),
        .any_busy (any_busy)
    );

    // Grants are combinational so the register-file port sees data the same cycle.
    always_comb begin
        alu_ready = 1'b0;
        lu_ready  = 1'b0;
        if (!rst) begin
            if (state_reg == ALU_PRI) begin
                alu_ready = alu_valid;
                lu_ready  = !alu_valid && lu_valid;
            end else begin
                lu_ready  = lu_valid;
            end
        end
    end

    assign rf_adr3 = lu_ready ? lu_rd : alu_rd;
    assign rf_wd3  = lu_ready ? lu_wd : alu_wd;
    assign rf_we   = (alu_ready && (alu_rd != '0)) || (lu_ready && (lu_rd != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ALU_PRI;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ALU_PRI: begin
                    if (alu_valid && lu_valid) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg >= CW'(STARVE_LIM - 1)) begin
                            state_reg <= LU_PRI;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
                default: begin
                    // Priority lasts for one grant, or ends if the long unit withdrew.
                    state_reg <= ALU_PRI;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule
